// File: rtl/seg7_pkg.sv
// Shared constants, FSM state type and small helpers for the seven-segment
// scan decoder. All segment patterns are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int unsigned SETTLE_CYCLES_DEFAULT = 4;

  localparam logic [6:0] PAT_0     = 7'h40;
  localparam logic [6:0] PAT_1     = 7'h79;
  localparam logic [6:0] PAT_2     = 7'h24;
  localparam logic [6:0] PAT_3     = 7'h30;
  localparam logic [6:0] PAT_4     = 7'h19;
  localparam logic [6:0] PAT_5     = 7'h12;
  localparam logic [6:0] PAT_6     = 7'h02;
  localparam logic [6:0] PAT_7     = 7'h78;
  localparam logic [6:0] PAT_8     = 7'h00;
  localparam logic [6:0] PAT_9     = 7'h10;
  localparam logic [6:0] PAT_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_CHANGE = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } scan_state_t;

  // True when exactly one anode line is driven low.
  function automatic logic one_low(input logic [7:0] an_v);
    logic [7:0] low_v;
    low_v = ~an_v;
    return (low_v != 8'h00) && ((low_v & (low_v - 8'h01)) == 8'h00);
  endfunction

  // Position of the low anode line; only meaningful when one_low() holds.
  function automatic logic [2:0] low_index(input logic [7:0] an_v);
    logic [2:0] idx_v;
    idx_v = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!an_v[i]) begin
        idx_v = 3'(i);
      end else begin
        idx_v = idx_v;
      end
    end
    return idx_v;
  endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// Pin-side bundle of the scan decoder: the multiplexed display lines going in
// and the captured digit state coming out.
interface seg7_scan_decoder_if;

  logic [7:0]  an;
  logic [6:0]  seg;
  logic [31:0] digits;
  logic [7:0]  digit_valid;
  logic [7:0]  digit_err;
  logic        new_digit;
  logic [2:0]  new_idx;
  logic        frame_done;

  // Display-driver side (drives the lines, observes the decoded result).
  modport master (
    output an, seg,
    input  digits, digit_valid, digit_err, new_digit, new_idx, frame_done
  );

  // Decoder side.
  modport slave (
    input  an, seg,
    output digits, digit_valid, digit_err, new_digit, new_idx, frame_done
  );

endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational lookup from an active-low segment pattern to a decimal value,
// with flags for a recognised digit and for the all-off blank pattern.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       is_digit,
  output logic       is_blank
);

  // Table lookup; anything not listed is neither a digit nor blank.
  always_comb begin
    value    = 4'd0;
    is_digit = 1'b1;
    is_blank = 1'b0;
    case (pattern)
      PAT_0:     value = 4'd0;
      PAT_1:     value = 4'd1;
      PAT_2:     value = 4'd2;
      PAT_3:     value = 4'd3;
      PAT_4:     value = 4'd4;
      PAT_5:     value = 4'd5;
      PAT_6:     value = 4'd6;
      PAT_7:     value = 4'd7;
      PAT_8:     value = 4'd8;
      PAT_9:     value = 4'd9;
      PAT_BLANK: begin
        is_digit = 1'b0;
        is_blank = 1'b1;
      end
      default: begin
        is_digit = 1'b0;
        is_blank = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Snoops a multiplexed seven-segment display: synchronises the anode/segment
// lines, waits for each pattern to stay stable, then captures it once per
// stable episode into a per-position digit register.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT,
  parameter logic [7:0]  DIGIT_MASK    = 8'h0F
) (
  input  logic                clk,
  input  logic                reset_n,
  seg7_scan_decoder_if.slave  bus
);

  localparam logic [7:0] SETTLE_MAX = SETTLE_CYCLES[7:0];

  logic [7:0]  sync_an1_r, sync_an2_r, prev_an_r;
  logic [6:0]  sync_seg1_r, sync_seg2_r, prev_seg_r;
  scan_state_t state_r, state_nxt_s, eff_state_s;
  logic [7:0]  cnt_r, cnt_nxt_s;
  logic [8:0]  cnt_inc_s;
  logic        qualified_s, restart_s, capture_s;
  logic [2:0]  idx_s;
  logic [3:0]  dec_value_s;
  logic        dec_digit_s, dec_blank_s;
  logic [7:0]  cap_bit_s, cover_s;
  logic        frame_hit_s;

  logic [7:0]  seen_r;
  logic [31:0] digits_r;
  logic [7:0]  digit_valid_r, digit_err_r;
  logic        new_digit_r, frame_done_r;
  logic [2:0]  new_idx_r;

  seg7_pattern_decode u_decode (
    .pattern  (sync_seg2_r),
    .value    (dec_value_s),
    .is_digit (dec_digit_s),
    .is_blank (dec_blank_s)
  );

  // Two-flop synchroniser for the asynchronous display lines.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_an1_r  <= 8'h00;
      sync_an2_r  <= 8'h00;
      sync_seg1_r <= 7'h00;
      sync_seg2_r <= 7'h00;
    end else begin
      sync_an1_r  <= bus.an;
      sync_an2_r  <= sync_an1_r;
      sync_seg1_r <= bus.seg;
      sync_seg2_r <= sync_seg1_r;
    end
  end

  // Sample classification: a sample that differs from the last one, or that
  // has zero / several anodes low, starts a fresh episode.
  always_comb begin
    qualified_s = one_low(sync_an2_r);
    idx_s       = low_index(sync_an2_r);
    restart_s   = (sync_an2_r != prev_an_r) || (sync_seg2_r != prev_seg_r) || !qualified_s;
    cap_bit_s   = 8'h01 << idx_s;
    cover_s     = seen_r | cap_bit_s;
    frame_hit_s = (DIGIT_MASK != 8'h00) && ((cover_s & DIGIT_MASK) == DIGIT_MASK);
  end

  // FSM state, stability counter and previous-sample register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_CHANGE;
      cnt_r      <= 8'd0;
      prev_an_r  <= 8'h00;
      prev_seg_r <= 7'h00;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      prev_an_r  <= sync_an2_r;
      prev_seg_r <= sync_seg2_r;
    end
  end

  // Next state and capture decision. A changed sample is handled as CHANGE in
  // the same cycle it is seen, so it already counts as the first stable
  // sample; this keeps the pin-to-strobe latency at 2 + SETTLE_CYCLES.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    capture_s   = 1'b0;
    cnt_inc_s   = {1'b0, cnt_r} + 9'd1;
    eff_state_s = restart_s ? ST_CHANGE : state_r;
    case (eff_state_s)
      ST_CHANGE: begin
        cnt_nxt_s = 8'd1;
        if (!qualified_s) begin
          state_nxt_s = ST_CHANGE;
        end else if (SETTLE_MAX == 8'd1) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_HELD;
        end else begin
          state_nxt_s = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_r >= SETTLE_MAX) begin
          cnt_nxt_s = SETTLE_MAX;
        end else begin
          cnt_nxt_s = cnt_inc_s[7:0];
        end
        if (cnt_inc_s == {1'b0, SETTLE_MAX}) begin
          capture_s   = 1'b1;
          state_nxt_s = ST_HELD;
        end else begin
          state_nxt_s = ST_SETTLE;
        end
      end
      ST_HELD: begin
        cnt_nxt_s   = cnt_r;
        state_nxt_s = ST_HELD;
      end
      default: begin
        cnt_nxt_s   = 8'd0;
        state_nxt_s = ST_CHANGE;
      end
    endcase
  end

  // Captured digit state, strobes and frame tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seen_r        <= 8'h00;
      digits_r      <= 32'h0000_0000;
      digit_valid_r <= 8'h00;
      digit_err_r   <= 8'h00;
      new_digit_r   <= 1'b0;
      new_idx_r     <= 3'd0;
      frame_done_r  <= 1'b0;
    end else if (capture_s) begin
      new_digit_r  <= 1'b1;
      new_idx_r    <= idx_s;
      frame_done_r <= frame_hit_s;
      seen_r       <= frame_hit_s ? (cap_bit_s & ~DIGIT_MASK) : cover_s;
      if (dec_digit_s) begin
        digits_r[{idx_s, 2'b00} +: 4] <= dec_value_s;
        digit_valid_r[idx_s]          <= 1'b1;
        digit_err_r[idx_s]            <= 1'b0;
      end else if (dec_blank_s) begin
        digits_r[{idx_s, 2'b00} +: 4] <= 4'h0;
        digit_valid_r[idx_s]          <= 1'b0;
        digit_err_r[idx_s]            <= 1'b0;
      end else begin
        digit_valid_r[idx_s]          <= 1'b0;
        digit_err_r[idx_s]            <= 1'b1;
      end
    end else begin
      new_digit_r  <= 1'b0;
      new_idx_r    <= 3'd0;
      frame_done_r <= 1'b0;
    end
  end

  assign bus.digits      = digits_r;
  assign bus.digit_valid = digit_valid_r;
  assign bus.digit_err   = digit_err_r;
  assign bus.new_digit   = new_digit_r;
  assign bus.new_idx     = new_idx_r;
  assign bus.frame_done  = frame_done_r;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scenarios followed by random display
// episodes, all compared each cycle against a pin-level behavioural model.
module tb_seg7_scan_decoder;

  localparam int         S    = 4;
  localparam logic [7:0] MASK = 8'h0F;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  seg7_scan_decoder_if bus();

  seg7_scan_decoder #(.SETTLE_CYCLES(S), .DIGIT_MASK(MASK)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int ecnt    = 0;
  int nd_seen = 0;
  int fd_seen = 0;
  int last_nd_edge = 0;

  // Pin values driven in each cycle; 0 marks cycles wiped by reset.
  bit   [14:0] hist [4096];
  logic [31:0] m_digits;
  logic [7:0]  m_valid, m_err, m_seen;
  logic [6:0]  dig_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit qual(input logic [7:0] a);
    return $countones(~a) == 1;
  endfunction

  // A capture happens when a qualified pin pattern has been held for exactly
  // S consecutive cycles ending at cycle idx.
  function automatic bit capture_at(input int idx);
    bit [14:0] v;
    int run, j;
    v = hist[idx];
    if (!qual(v[14:7])) return 1'b0;
    run = 1;
    j = idx - 1;
    while (j >= 0 && run <= S && hist[j] == v) begin
      run++;
      j--;
    end
    return run == S;
  endfunction

  task automatic tick(input logic [7:0] a, input logic [6:0] s, input bit rst);
    int k, pos, val;
    bit exp_nd, exp_fd;
    logic [2:0] exp_idx;
    bit [14:0] v;
    k = ecnt;
    bus.an  = a;
    bus.seg = s;
    reset_n = !rst;
    if (rst) begin
      hist[k] = '0;
      if (k >= 1) hist[k-1] = '0;
      if (k >= 2) hist[k-2] = '0;
    end else begin
      hist[k] = {a, s};
    end
    @(posedge clk);
    ecnt++;
    #1;
    exp_nd = 1'b0; exp_fd = 1'b0; exp_idx = 3'd0;
    if (rst) begin
      m_digits = '0; m_valid = '0; m_err = '0; m_seen = '0;
    end else if (ecnt >= 3 && capture_at(ecnt - 3)) begin
      v = hist[ecnt - 3];
      exp_nd = 1'b1;
      pos = 0;
      for (int i = 0; i < 8; i++) if (!v[7+i]) pos = i;
      exp_idx = 3'(pos);
      val = -1;
      for (int d = 0; d < 10; d++) if (dig_tab[d] == v[6:0]) val = d;
      if (val >= 0) begin
        m_digits[pos*4 +: 4] = 4'(val); m_valid[pos] = 1'b1; m_err[pos] = 1'b0;
      end else if (v[6:0] == 7'h7F) begin
        m_digits[pos*4 +: 4] = 4'h0; m_valid[pos] = 1'b0; m_err[pos] = 1'b0;
      end else begin
        m_valid[pos] = 1'b0; m_err[pos] = 1'b1;
      end
      m_seen[pos] = 1'b1;
      if ((MASK != 8'h00) && ((m_seen & MASK) == MASK)) begin
        exp_fd = 1'b1;
        m_seen = (8'h01 << pos) & ~MASK;
      end
    end
    if (bus.new_digit === 1'b1) begin
      nd_seen++;
      last_nd_edge = ecnt;
    end
    if (bus.frame_done === 1'b1) fd_seen++;
    check("new_digit", 32'(bus.new_digit), 32'(exp_nd));
    check("frame_done", 32'(bus.frame_done), 32'(exp_fd));
    if (exp_nd) check("new_idx", 32'(bus.new_idx), 32'(exp_idx));
    check("digits", bus.digits, m_digits);
    check("digit_valid", 32'(bus.digit_valid), 32'(m_valid));
    check("digit_err", 32'(bus.digit_err), 32'(m_err));
  endtask

  initial begin
    int nd0, fd0, rel, r, len;
    logic [7:0] a;
    logic [6:0] s;
    bit rr;
    m_digits = '0; m_valid = '0; m_err = '0; m_seen = '0;
    bus.an  = 8'hFF;
    bus.seg = 7'h7F;

    // Reset: everything zero.
    repeat (3) tick(8'hFF, 7'h7F, 1'b1);

    // Single stable digit 3 at position 0.
    nd0 = nd_seen; rel = ecnt;
    repeat (10) tick(8'hFE, 7'h30, 1'b0);
    check("single_capture_count", 32'(nd_seen - nd0), 32'd1);
    check("single_capture_latency", 32'(last_nd_edge - rel), 32'd6);
    check("single_nibble0", 32'(bus.digits[3:0]), 32'h3);
    check("single_valid0", 32'(bus.digit_valid[0]), 32'd1);

    // Scan positions 0..3 with 1,2,3,4.
    nd0 = nd_seen; fd0 = fd_seen;
    for (int p = 0; p < 4; p++) repeat (8) tick(~(8'h01 << p), dig_tab[p+1], 1'b0);
    check("scan_strobes", 32'(nd_seen - nd0), 32'd4);
    check("scan_frames", 32'(fd_seen - fd0), 32'd1);
    check("scan_digits", 32'(bus.digits[15:0]), 32'h4321);

    // Pattern toggling faster than the settle time.
    nd0 = nd_seen;
    for (int t = 0; t < 4; t++) begin
      repeat (3) tick(8'hFB, 7'h24, 1'b0);
      repeat (3) tick(8'hFB, 7'h7F, 1'b0);
    end
    check("bounce_no_capture", 32'(nd_seen - nd0), 32'd0);

    // Unrecognised pattern at position 3.
    repeat (10) tick(8'hF7, 7'h55, 1'b0);
    check("bad_err3", 32'(bus.digit_err[3]), 32'd1);
    check("bad_valid3", 32'(bus.digit_valid[3]), 32'd0);
    check("bad_nibble3_kept", 32'(bus.digits[15:12]), 32'h4);

    // Two anodes low.
    nd0 = nd_seen;
    repeat (20) tick(8'hFC, 7'h7F, 1'b0);
    check("two_anodes_no_capture", 32'(nd_seen - nd0), 32'd0);

    // Reset mid-settle, pattern held across it.
    nd0 = nd_seen;
    repeat (5) tick(8'hFD, 7'h79, 1'b0);
    repeat (2) tick(8'hFD, 7'h79, 1'b1);
    rel = ecnt;
    repeat (10) tick(8'hFD, 7'h79, 1'b0);
    check("reset_capture_count", 32'(nd_seen - nd0), 32'd1);
    check("reset_capture_latency", 32'(last_nd_edge - rel), 32'd6);

    // Random display episodes.
    for (int ep = 0; ep < 250; ep++) begin
      r = $urandom_range(0, 99);
      if (r < 80) a = ~(8'h01 << $urandom_range(0, 7));
      else        a = 8'($urandom);
      r = $urandom_range(0, 99);
      if (r < 60)      s = dig_tab[$urandom_range(0, 9)];
      else if (r < 70) s = 7'h7F;
      else             s = 7'($urandom);
      len = $urandom_range(1, 8);
      rr  = ($urandom_range(0, 29) == 0);
      repeat (len) tick(a, s, 1'b0);
      if (rr) repeat ($urandom_range(1, 2)) tick(a, s, 1'b1);
    end
    repeat (8) tick(8'hFF, 7'h7F, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
